cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling controller that sits between the instruction/data caches and multi-cycle main memory, upstream of the CPU core. On a cache miss it fetches the full 16-byte block as eight 16-bit words. It issues one pipelined read per cycle, steers each returned word into the cache data array, and writes the tag array on the final word. The core stalls on `fsm_busy`.

## Interface
Parameters:
- `ADDR_W`, 16, byte-address width.
- `WORDS_PER_BLOCK`, 8, 16-bit words per cache block; fixed at 8 in this revision.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `miss_detected`  in  1  level; cache reports a miss; held by the cache until the tag is written.
- `miss_address`  in  16  byte address of the missing access.
- `memory_data`  in  16  read data from main memory.
- `memory_data_valid`  in  1  `memory_data` valid this cycle.
- `fsm_busy`  out  1  fill in progress; core must stall.
- `memory_en`  out  1  read request to main memory this cycle.
- `memory_address`  out  16  byte address of the request.
- `write_data_array`  out  1  data-array word write enable.
- `cache_word_sel`  out  3  word offset written this cycle.
- `cache_data`  out  16  word to write; equals `memory_data`.
- `write_tag_array`  out  1  single-cycle tag/valid write pulse.
- `fill_done`  out  1  single-cycle completion pulse; coincident with `write_tag_array`.

## Operation
- States: IDLE, FILL, CLEAR.
- IDLE -> FILL when `miss_detected`=1.
  - Latch `base = {miss_address[15:4], 4'b0}`.
  - Latch `crit = miss_address[3:1]`.
  - Clear `req_cnt` (4 bits) and `rcv_cnt` (4 bits).
- FILL, request side:
  - `memory_en` = (`req_cnt` < 8).
  - `memory_address` = `base` + 2·`order(req_cnt)`.
  - `req_cnt` increments each cycle while `memory_en`=1, so requests go out on 8 consecutive cycles.
  - Memory is pipelined. There is no backpressure.
- FILL, response side:
  - On each `memory_data_valid`=1 while `rcv_cnt` < 8: `write_data_array`=1, `cache_word_sel` = `order(rcv_cnt)`, and `rcv_cnt` increments.
  - The FSM counts valids and has no dependence on memory latency.
- On the valid with `rcv_cnt`=7: `write_tag_array`=1 and `fill_done`=1, combinationally in the same cycle. Next state is CLEAR.
- CLEAR: one cycle. `miss_detected` is ignored so the cache's registered miss can drop. Then -> IDLE.
- `fsm_busy` = state != IDLE.
- `order(i)` = `i[2:0]` (sequential). See Configuration for the alternative.
- Address arithmetic is 16-bit. The offset never carries out of the block because `base[3:0]`=0.
- `memory_data_valid` is ignored in IDLE and CLEAR, and for any valid beyond the eighth.
- `miss_address` changes during FILL are ignored; only the latched value is used.

## Timing
- Reset (async, `rst_n`=0):
  - State goes to IDLE; counters, `base` and `crit` go to 0.
  - All outputs are 0, except `cache_data`, which follows `memory_data`.
  - Reset mid-fill abandons the fill. In-flight memory returns after release are ignored, because they arrive in IDLE.
- Cycle 0: IDLE with miss sampled. Cycles 1–8: FILL with `memory_en`=1.
- With memory latency L, valids arrive in cycles 1+L..8+L. `fill_done` is in cycle 8+L, CLEAR is in 9+L, and the FSM is back in IDLE in 10+L.
- The earliest next miss is accepted in cycle 10+L.
- `write_data_array`, `cache_word_sel`, `write_tag_array` and `fill_done` are combinational from state plus `memory_data_valid`. All other outputs derive from registers only.

## Configuration
- `CACHE_FILL_CRITICAL_FIRST_EN` defined: critical word first.
  - `order(i)` = (`crit` + `i[2:0]`) mod 8, wrapping within the block, for both requests and data-array writes.
- Not defined: `order(i)` = `i[2:0]`. `crit` is neither stored nor synthesized.

## Structure
- `cache_pkg` contains:
  - state enum `fill_state_t` {IDLE, FILL, CLEAR};
  - constants `BLOCK_BYTES`=16, `WORDS_PER_BLOCK`=8, `OFFSET_W`=3, `CNT_W`=4.
- One sub-module, `fill_counter`:
  - 4-bit counter with clear, enable and saturation at 8;
  - outputs `count` and the wrapped offset `order`;
  - instantiated twice, for requests and for responses.

## Test plan
- Basic fill, L=4, `miss_address`=0x1234:
  - `memory_address` = 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - `write_data_array` in cycles 5–12 with `cache_word_sel` 0..7.
  - `fill_done`/`write_tag_array` pulse in cycle 12; `fsm_busy` low in cycle 14.
- Critical-first (macro defined), `miss_address`=0xABCE:
  - requests start at 0xABCE, then wrap to 0xABC0 … 0xABCC;
  - `cache_word_sel` sequence is 7,0,1,…,6.
- Irregular latency, valids with gaps (pattern 1,0,0,1,1,0,…):
  - exactly eight writes with `cache_word_sel` in order;
  - `fill_done` coincides with the eighth valid.
- Spurious valids:
  - `memory_data_valid`=1 in IDLE and CLEAR causes no writes;
  - a ninth valid after `fill_done` is ignored.
- Reset asserted in cycle 6 of a fill:
  - all outputs go to 0 immediately;
  - valids arriving after release cause no writes;
  - a new miss then starts a clean fill from word 0.
- `miss_detected` held high through CLEAR: no second fill starts until the cycle after CLEAR.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill controller.
//
// Contents:
//   fill_state_t    - controller state encoding (IDLE, FILL, CLEAR)
//   BLOCK_BYTES     - bytes per cache block
//   WORDS_PER_BLOCK - 16-bit words per cache block
//   OFFSET_W        - width of a word offset inside a block
//   CNT_W           - width of the request/response counters (counts 0..8)
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CLEAR = 2'd2
    } fill_state_t;

    localparam int BLOCK_BYTES     = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_W        = 3;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/fill_counter.sv
// Word counter used by the fill controller, once for issued requests and
// once for received words.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear to 0 (wins over en)
//   en          - count up by one; the counter holds at WORDS_PER_BLOCK
//   crit        - critical word offset (only with CACHE_FILL_CRITICAL_FIRST_EN)
//   count       - current count, 0..WORDS_PER_BLOCK
//   order       - word offset inside the block for the current count
//
// Build option: CACHE_FILL_CRITICAL_FIRST_EN rotates the word order so the
// sequence starts at crit and wraps within the block.
module fill_counter
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    input  logic [OFFSET_W-1:0] crit,
`endif
    output logic [CNT_W-1:0]    count,
    output logic [OFFSET_W-1:0] order
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q < CNT_W'(WORDS_PER_BLOCK))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    // 3-bit add wraps naturally inside the block.
    assign order = crit + count_q[OFFSET_W-1:0];
`else
    assign order = count_q[OFFSET_W-1:0];
`endif

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller. On a miss it reads the whole 16-byte block from
// pipelined main memory as eight 16-bit words, one request per cycle, writes
// each returned word into the data array and writes the tag array together
// with the last word. The core stalls while fsm_busy is high.
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   miss_detected      - cache miss (level, held until the tag is written)
//   miss_address       - byte address of the missing access
//   memory_data        - read data returned by memory
//   memory_data_valid  - memory_data valid this cycle
//   fsm_busy           - fill in progress (registered)
//   memory_en          - read request this cycle (registered)
//   memory_address     - request byte address (registered)
//   write_data_array   - data-array word write enable (combinational)
//   cache_word_sel     - word offset being written (combinational)
//   cache_data         - word being written, straight from memory_data
//   write_tag_array    - tag/valid write pulse (combinational)
//   fill_done          - fill completion pulse, same cycle as write_tag_array
//
// Build option: CACHE_FILL_CRITICAL_FIRST_EN fetches and writes the missing
// word first and wraps through the rest of the block.
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [15:0]       memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              memory_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [2:0]        cache_word_sel,
    output logic [15:0]       cache_data,
    output logic              write_tag_array,
    output logic              fill_done
);

    import cache_pkg::*;

    fill_state_t state_q;
    fill_state_t state_d;

    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   base_d;

    logic                fill_start;
    logic [CNT_W-1:0]    req_cnt;
    logic [OFFSET_W-1:0] req_order;
    logic [CNT_W-1:0]    rcv_cnt;
    logic [OFFSET_W-1:0] rcv_order;
    logic                last_word;

    // Low address bits only matter for the critical word, if at all.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^miss_address[3:0];

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    logic [OFFSET_W-1:0] crit_q;
    logic [OFFSET_W-1:0] crit_d;
`endif

    // The counters are cleared whenever a miss is seen in IDLE, which is
    // exactly the cycle the fill is accepted.
    assign fill_start = (state_q == IDLE) && miss_detected;

    fill_counter u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fill_start),
        .en    (memory_en),
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        .crit  (crit_q),
`endif
        .count (req_cnt),
        .order (req_order)
    );

    fill_counter u_rcv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fill_start),
        .en    (write_data_array),
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        .crit  (crit_q),
`endif
        .count (rcv_cnt),
        .order (rcv_order)
    );

    // Response side: every valid in FILL up to the eighth is a word write.
    always_comb begin
        write_data_array = 1'b0;
        cache_word_sel   = '0;
        last_word        = 1'b0;
        if ((state_q == FILL) && memory_data_valid &&
            (rcv_cnt < CNT_W'(WORDS_PER_BLOCK))) begin
            write_data_array = 1'b1;
            cache_word_sel   = rcv_order;
            last_word        = (rcv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
        end
    end

    assign write_tag_array = last_word;
    assign fill_done       = last_word;
    assign cache_data      = memory_data;

    // Request side is driven from registers only.
    assign fsm_busy       = (state_q != IDLE);
    assign memory_en      = (state_q == FILL) &&
                            (req_cnt < CNT_W'(WORDS_PER_BLOCK));
    assign memory_address = base_q + ADDR_W'({req_order, 1'b0});

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        crit_d  = crit_q;
`endif
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d = FILL;
                    base_d  = {miss_address[ADDR_W-1:4], 4'b0000};
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
                    crit_d  = miss_address[3:1];
`endif
                end
            end
            FILL: begin
                if (last_word) begin
                    state_d = CLEAR;
                end
            end
            // One dead cycle so the cache's registered miss can drop before
            // the controller looks at it again.
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
            crit_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
            crit_q  <= crit_d;
`endif
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed fills plus randomized
// fills, checked every cycle against a block-fill reference model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  cache_word_sel;
    logic [15:0] cache_data;
    logic        write_tag_array;
    logic        fill_done;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 filling, 2 post-fill dead cycle.
    int          m_phase;
    int          m_req;
    int          m_rcv;
    logic [15:0] m_base;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    int          m_crit;
`endif

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_en         (memory_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .cache_word_sel    (cache_word_sel),
        .cache_data        (cache_data),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Word offset of the i-th word of a fill.
    function automatic int word_of(input int i);
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        return (m_crit + i) % 8;
`else
        return i % 8;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_req   = 0;
        m_rcv   = 0;
        m_base  = 16'h0000;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        m_crit  = 0;
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(fsm_busy), 32'd0);
        chk({tag, "_en"},   32'(memory_en), 32'd0);
        chk({tag, "_addr"}, 32'(memory_address), 32'd0);
        chk({tag, "_wr"},   32'(write_data_array), 32'd0);
        chk({tag, "_sel"},  32'(cache_word_sel), 32'd0);
        chk({tag, "_tag"},  32'(write_tag_array), 32'd0);
        chk({tag, "_done"}, 32'(fill_done), 32'd0);
        chk({tag, "_data"}, 32'(cache_data), 32'(memory_data));
    endtask

    // One clock: drive inputs, check outputs, advance the model.
    task automatic step(input logic miss, input logic [15:0] addr, input logic v,
                        output logic done_o);
        logic [15:0] dat;
        logic        e_en;
        logic        e_wr;
        logic        e_done;
        dat               = 16'($urandom);
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = v;
        memory_data       = dat;
        #2;
        e_en   = (m_phase == 1) && (m_req < 8);
        e_wr   = (m_phase == 1) && v && (m_rcv < 8);
        e_done = e_wr && (m_rcv == 7);
        chk("busy", 32'(fsm_busy), 32'(m_phase != 0));
        chk("mem_en", 32'(memory_en), 32'(e_en));
        if (e_en)
            chk("mem_addr", 32'(memory_address), 32'(m_base + 16'(2 * word_of(m_req))));
        chk("wr_data", 32'(write_data_array), 32'(e_wr));
        if (e_wr)
            chk("word_sel", 32'(cache_word_sel), 32'(word_of(m_rcv)));
        chk("wr_tag", 32'(write_tag_array), 32'(e_done));
        chk("fill_done", 32'(fill_done), 32'(e_done));
        chk("cache_data", 32'(cache_data), 32'(dat));
        done_o = e_done;
        @(posedge clk);
        #1;
        case (m_phase)
            0: if (miss) begin
                m_phase = 1;
                m_base  = addr & 16'hFFF0;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
                m_crit  = (addr >> 1) % 8;
`endif
                m_req   = 0;
                m_rcv   = 0;
            end
            1: begin
                if (e_en) m_req++;
                if (e_wr) m_rcv++;
                if (e_done) m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    // Full fill starting with an IDLE miss cycle, followed by the dead cycle.
    // mode 0: fixed latency, mode 1: 1,0,0,1,1,0 valid pattern, else random.
    task automatic run_fill(input logic [15:0] addr, input int lat, input int mode,
                            input logic hold_clear, input logic spur);
        int          cyc;
        int          sent;
        logic        d;
        logic        done_seen;
        logic        v;
        logic [5:0]  pat;
        cyc       = 0;
        sent      = 0;
        done_seen = 1'b0;
        pat       = 6'b011001;
        while (!done_seen && cyc < 80) begin
            case (mode)
                0:       v = (cyc >= 1 + lat) && (sent < 8);
                1:       v = (cyc >= 1) && pat[(cyc - 1) % 6] && (sent < 8);
                default: v = (cyc >= 1 + lat) && ($urandom_range(0, 3) != 0);
            endcase
            sent += int'(v);
            // Address wiggles after the miss cycle must be ignored.
            step(1'b1, (cyc == 0) ? addr : 16'($urandom), v, d);
            done_seen = d;
            cyc++;
        end
        n_assert++;
        assert (done_seen) else begin
            n_fail++;
            $error("FAIL fill_timeout: observed no completion after %0d cycles, expected completion", cyc);
        end
        step(hold_clear, addr, spur, d);
    endtask

    initial begin
        logic d;
        rst_n             = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data       = 16'h0000;
        memory_data_valid = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_reset("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Valids while idle write nothing.
        step(1'b0, 16'h0000, 1'b1, d);
        step(1'b0, 16'h0000, 1'b1, d);

        run_fill(16'h1234, 4, 0, 1'b0, 1'b0);
        step(1'b0, 16'h1234, 1'b1, d);
        run_fill(16'hABCE, 2, 0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, d);
        run_fill(16'h3C5A, 0, 1, 1'b1, 1'b1);
        run_fill(16'h3C5A, 3, 0, 1'b0, 1'b0);

        // Reset in cycle 6 of a fill.
        step(1'b1, 16'h5678, 1'b0, d);
        for (int c = 1; c < 6; c++) step(1'b1, 16'($urandom), (c >= 3), d);
        miss_detected     = 1'b1;
        memory_data_valid = 1'b1;
        memory_data       = 16'($urandom);
        #1 rst_n = 1'b0;
        #1 model_reset();
        chk_reset("reset_mid");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) step(1'b0, 16'h5678, 1'b1, d);
        run_fill(16'h5678, 2, 0, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            run_fill(16'($urandom), $urandom_range(0, 6), 2,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) != 0) step(1'b0, 16'h0000, 1'($urandom_range(0, 1)), d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
